// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator layer chain.
package cnn_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LAUNCH = 3'd1,
    SEQ_WAIT   = 3'd2,
    SEQ_SWAP   = 3'd3,
    SEQ_FINISH = 3'd4,
    SEQ_ERROR  = 3'd5
  } seq_state_t;

  // Selects one of the two feature-map RAM banks.
  typedef logic bank_sel_t;

  // Default per-layer run limit, shared with the layer modules.
  localparam int unsigned CNN_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Host, layer-handshake and bank-steering signals of the layer sequencer.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
);
  import cnn_pkg::*;

  logic                  start;
  logic                  abort;
  logic                  host_req;
  logic                  host_grant;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_done;
  bank_sel_t             bank_sel_rd;
  logic [LAYER_W-1:0]    cur_layer;
  logic                  busy;
  logic                  done;
  bank_sel_t             final_bank;
  logic                  error;

  // Host and layers drive the master side; the sequencer is the slave.
  modport master (
    output start, abort, host_req, layer_done,
    input  host_grant, layer_start, bank_sel_rd, cur_layer, busy, done, final_bank, error
  );

  modport slave (
    input  start, abort, host_req, layer_done,
    output host_grant, layer_start, bank_sel_rd, cur_layer, busy, done, final_bank, error
  );

endinterface

// File: rtl/layer_watchdog.sv
// Per-layer run-time counter; timeout is high once TIMEOUT_CYCLES-1 is reached.
module layer_watchdog
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign timeout = (count == LIMIT);

  // Saturates at the limit so a stalled layer cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !timeout) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer-chain scheduler: launches layers in order, ping-pongs the feature-map
// banks, arbitrates the RAM against the host loader and watches each layer.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int          NUM_LAYERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES,
  parameter int          LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input logic                  clk,
  input logic                  rst,
  cnn_layer_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = SEQ_IDLE;
  localparam logic [2:0] S_LAUNCH = SEQ_LAUNCH;
  localparam logic [2:0] S_WAIT   = SEQ_WAIT;
  localparam logic [2:0] S_SWAP   = SEQ_SWAP;
  localparam logic [2:0] S_FINISH = SEQ_FINISH;
  localparam logic [2:0] S_ERROR  = SEQ_ERROR;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [LAYER_W-1:0] cur_nxt;
  bank_sel_t          bank_nxt;
  logic               error_nxt;
  logic               cur_done;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_timeout;

  // Only the active layer's done bit can advance the chain.
  assign cur_done = bus.layer_done[bus.cur_layer];
  assign wd_clr   = (state == S_LAUNCH);
  assign wd_en    = (state == S_WAIT);

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (wd_timeout)
  );

  // NOTE: every next-state value gets a hold default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cur_nxt   = bus.cur_layer;
    bank_nxt  = bus.bank_sel_rd;
    error_nxt = bus.error;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.host_grant) begin
          state_nxt = S_LAUNCH;
          cur_nxt   = '0;
          bank_nxt  = 1'b0;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cur_done) begin
          state_nxt = S_SWAP;
        end else if (wd_timeout) begin
          state_nxt = S_ERROR;
          error_nxt = 1'b1;
        end
      end
      S_SWAP: begin
        bank_nxt = ~bus.bank_sel_rd;
        if (bus.cur_layer == LAST_LAYER) begin
          state_nxt = S_FINISH;
        end else begin
          cur_nxt   = bus.cur_layer + LAYER_W'(1);
          state_nxt = S_LAUNCH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
    // Abort leaves the bank/layer pointers alone; layers are reset externally.
    if (bus.abort) begin
      state_nxt = S_IDLE;
      cur_nxt   = bus.cur_layer;
      bank_nxt  = bus.bank_sel_rd;
      error_nxt = 1'b0;
    end
  end

  // NOTE: registers use non-blocking assignments so every output below sees
  // the pre-edge values and the block has no ordering dependence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      bus.cur_layer   <= '0;
      bus.bank_sel_rd <= 1'b0;
      bus.final_bank  <= 1'b0;
      bus.layer_start <= '0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.error       <= 1'b0;
      bus.host_grant  <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.cur_layer   <= cur_nxt;
      bus.bank_sel_rd <= bank_nxt;
      bus.error       <= error_nxt;
      // Outputs are decoded from the next state so they align with it.
      bus.layer_start <= (state_nxt == S_LAUNCH) ? (NUM_LAYERS'(1) << cur_nxt) : '0;
      bus.done        <= (state_nxt == S_FINISH);
      bus.busy        <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT) ||
                         (state_nxt == S_SWAP)   || (state_nxt == S_FINISH);
      bus.host_grant  <= (state == S_IDLE) && (state_nxt == S_IDLE) &&
                         !bus.abort && bus.host_req;
      if (state_nxt == S_FINISH) begin
        bus.final_bank <= bank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench: a 4-layer and a 3-layer sequencer share stimulus and are
// compared every cycle against a schedule model built from layer latencies.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  localparam int TMO = 16;

  typedef struct packed {
    logic [3:0] ls;
    logic       busy;
    logic       done;
    logic       bank;
    logic [1:0] cur;
    logic       fin;
    logic       grant;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       host_req;
  logic [3:0] ld;

  int   n_vec = 0;
  int   n_err = 0;
  int   s[5];
  int   d[4];
  int   err_l;
  logic fin4;
  logic fin3;

  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.NUM_LAYERS(4)) if4 ();
  cnn_layer_sequencer_if #(.NUM_LAYERS(3)) if3 ();

  assign if4.start      = start;
  assign if4.abort      = abort;
  assign if4.host_req   = host_req;
  assign if4.layer_done = ld;
  assign if3.start      = start;
  assign if3.abort      = abort;
  assign if3.host_req   = host_req;
  assign if3.layer_done = ld[2:0];

  cnn_layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT_CYCLES(TMO)) dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave)
  );
  cnn_layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave)
  );

  function automatic obs_t get4();
    return {if4.layer_start, if4.busy, if4.done, if4.bank_sel_rd, if4.cur_layer,
            if4.final_bank, if4.host_grant, if4.error};
  endfunction

  function automatic obs_t get3();
    return {1'b0, if3.layer_start, if3.busy, if3.done, if3.bank_sel_rd, if3.cur_layer,
            if3.final_bank, if3.host_grant, if3.error};
  endfunction

  // Expected outputs during cycle c of a run whose start was sampled at the
  // end of cycle 0. Layer i launches at s[i], runs d[i] wait cycles, then one
  // swap cycle; layer err_l never finishes and trips the watchdog.
  function automatic obs_t model(int n, int c, logic hreq, logic fin_prev);
    obs_t e = '0;
    e.fin = fin_prev;
    for (int i = 0; i < n; i++) begin
      if (c >= s[i] && (i == err_l || c <= s[i] + d[i] + 1)) begin
        e.cur  = 2'(i);
        e.bank = i[0];
        if (i == err_l && c > s[i] + TMO) begin
          e.err = 1'b1;
        end else begin
          e.busy = 1'b1;
          if (c == s[i]) e.ls = 4'(1 << i);
        end
        return e;
      end
    end
    e.cur  = 2'(n - 1);
    e.bank = n[0];
    if (c >= s[n]) e.fin = n[0];
    if (c == s[n]) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else if (c >= s[n] + 2) begin
      e.grant = hreq;
    end
    return e;
  endfunction

  // mode 0: quiet bus, 1: random noise, 2: every non-awaited bit held high.
  function automatic logic [3:0] stim_done(int c, int mode);
    logic [3:0] v;
    v = (mode == 2) ? 4'hf : (mode == 1) ? 4'($urandom) : 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (err_l >= 0 && i > err_l) break;
      if (c > s[i] && (i == err_l || c <= s[i] + d[i]))
        v[i] = (i != err_l) && (c == s[i] + d[i]);
    end
    return v;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_chain(input int mode, input logic hreq);
    int last;
    s[0] = 1;
    for (int i = 0; i < 4; i++) s[i+1] = s[i] + d[i] + 2;
    last = (err_l >= 0) ? s[err_l] + TMO + 3 : s[4] + 2;
    @(negedge clk);
    start    = 1'b1;
    host_req = hreq;
    ld       = '0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("run4 c=%0d", c), get4(), model(4, c, hreq, fin4));
      check($sformatf("run3 c=%0d", c), get3(), model(3, c, hreq, fin3));
      ld = stim_done(c, mode);
    end
    ld       = '0;
    host_req = 1'b0;
    if (err_l < 0) begin
      fin4 = 1'b0;
      fin3 = 1'b1;
    end
  endtask

  initial begin
    obs_t e;
    start    = 1'b0;
    abort    = 1'b0;
    host_req = 1'b0;
    ld       = '0;
    err_l    = -1;
    fin4     = 1'b0;
    fin3     = 1'b0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    #3;
    check("reset4", get4(), '0);
    check("reset3", get3(), '0);
    @(negedge clk);
    rst = 1'b1;

    // Fixed 10-cycle layers with wrong-index and launch-cycle done bits high.
    d = '{10, 10, 10, 10};
    run_chain(2, 1'b0);

    repeat (5) begin
      foreach (d[i]) d[i] = $urandom_range(1, TMO);
      run_chain(1, 1'($urandom_range(0, 1)));
    end

    // Shortest and longest latencies that still complete.
    d = '{1, TMO, 1, TMO};
    run_chain(1, 1'b1);

    // Host grant in IDLE blocks start; dropping the request drops the grant.
    @(negedge clk);
    host_req = 1'b1;
    @(negedge clk);
    check("grant4_on", get4(), model(4, 1 << 20, 1'b1, fin4));
    check("grant3_on", get3(), model(3, 1 << 20, 1'b1, fin3));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("grant4_start_ignored", get4(), model(4, 1 << 20, 1'b1, fin4));
    check("grant3_start_ignored", get3(), model(3, 1 << 20, 1'b1, fin3));
    host_req = 1'b0;
    @(negedge clk);
    check("grant4_off", get4(), model(4, 1 << 20, 1'b0, fin4));
    check("grant3_off", get3(), model(3, 1 << 20, 1'b0, fin3));

    // Layer 1 never completes.
    d     = '{10, 0, 0, 0};
    err_l = 1;
    run_chain(1, 1'b0);
    start    = 1'b1;
    host_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("err4_hold", get4(), model(4, 1 << 20, 1'b1, fin4));
      check("err3_hold", get3(), model(3, 1 << 20, 1'b1, fin3));
    end
    start    = 1'b0;
    host_req = 1'b0;
    abort    = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    e = '0;
    e.cur  = 2'd1;
    e.bank = 1'b1;
    e.fin  = fin4;
    check("abort4", get4(), e);
    e.fin = fin3;
    check("abort3", get3(), e);
    err_l = -1;
    foreach (d[i]) d[i] = $urandom_range(1, TMO);
    run_chain(1, 1'b0);

    // Asynchronous reset between clock edges while layer 0 waits.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset4", get4(), '0);
    check("midreset3", get3(), '0);
    @(negedge clk);
    rst  = 1'b1;
    fin4 = 1'b0;
    fin3 = 1'b0;
    foreach (d[i]) d[i] = $urandom_range(1, TMO);
    run_chain(1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
